// File: rtl/fcvt_ws_seq.sv
// Sequential FCVT.W.S / FCVT.WU.S: bit-serial alignment shifter followed by a
// rounding and saturation step. The classifier vector selects the special cases.
module fcvt_ws_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] frs,
  input  logic [9:0]  class_res,
  input  logic [2:0]  rm,
  input  logic        is_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags,
  output logic [1:0]  state_dbg
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Each side
  // holds its payload stable while its valid is high and not yet accepted.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic [32:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic        sign_q, sign_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic        force_q, force_d;
  logic [31:0] force_res_q, force_res_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  fflags_q, fflags_d;
  logic        out_valid_q, out_valid_d;

  // Accept-time decode of the operand
  logic signed [9:0] e_c;
  logic        is_nan, is_zero, is_sub, is_norm;
  logic        acc_force;
  logic [31:0] acc_force_res;
  logic [32:0] acc_mag;
  logic        acc_sticky;
  logic        acc_shift;
  logic        acc_left;
  logic [4:0]  acc_cnt;

  always_comb begin
    e_c           = $signed({2'b00, frs[30:23]}) - 10'sd127;
    is_nan        = class_res[9] | class_res[8];
    is_zero       = class_res[4] | class_res[3];
    is_sub        = class_res[5] | class_res[2];
    is_norm       = class_res[6] | class_res[1];
    acc_force     = 1'b0;
    acc_force_res = 32'h0;
    acc_mag       = 33'h0;
    acc_sticky    = 1'b0;
    acc_shift     = 1'b0;
    acc_left      = 1'b0;
    acc_cnt       = 5'd0;
    if (is_nan) begin
      acc_force     = 1'b1;
      acc_force_res = is_unsigned ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (class_res[7] || (class_res[6] && e_c >= 10'sd32)) begin
      acc_force     = 1'b1;
      acc_force_res = is_unsigned ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
    end else if (class_res[0] || (class_res[1] && e_c >= 10'sd32)) begin
      acc_force     = 1'b1;
      acc_force_res = is_unsigned ? 32'h0000_0000 : 32'h8000_0000;
    end else if (is_zero) begin
      acc_sticky = 1'b0;
    end else if (is_sub || (is_norm && e_c < -10'sd1)) begin
      // Magnitude below one half: integer part 0, only sticky survives.
      acc_sticky = 1'b1;
    end else if (is_norm) begin
      acc_shift = 1'b1;
      acc_mag   = {9'b0, 1'b1, frs[22:0]};
      if (e_c <= 10'sd22) begin
        acc_cnt = 5'd23 - e_c[4:0];
      end else begin
        acc_left = 1'b1;
        acc_cnt  = e_c[4:0] - 5'd23;
      end
    end
  end

  // Rounding and range check on the aligned magnitude
  logic        rnd_inc;
  logic        gs;
  logic [32:0] m_r;
  logic [31:0] rnd_res;
  logic        rnd_nv;
  logic        rnd_nx;

  always_comb begin
    gs = guard_q | sticky_q;
    case (rm_q)
      3'b000:  rnd_inc = guard_q & (sticky_q | mag_q[0]);
      3'b010:  rnd_inc = sign_q & gs;
      3'b011:  rnd_inc = ~sign_q & gs;
      3'b100:  rnd_inc = guard_q;
      default: rnd_inc = 1'b0;
    endcase
    m_r     = mag_q + {32'b0, rnd_inc};
    rnd_res = 32'h0;
    rnd_nv  = 1'b0;
    if (force_q) begin
      rnd_res = force_res_q;
      rnd_nv  = 1'b1;
    end else if (!uns_q) begin
      if (!sign_q && m_r > 33'h0_7FFF_FFFF) begin
        rnd_res = 32'h7FFF_FFFF;
        rnd_nv  = 1'b1;
      end else if (sign_q && m_r > 33'h0_8000_0000) begin
        rnd_res = 32'h8000_0000;
        rnd_nv  = 1'b1;
      end else begin
        rnd_res = sign_q ? (~m_r[31:0] + 32'd1) : m_r[31:0];
      end
    end else begin
      if (sign_q) begin
        rnd_res = 32'h0;
        rnd_nv  = (m_r != 33'h0);
      end else if (m_r[32]) begin
        rnd_res = 32'hFFFF_FFFF;
        rnd_nv  = 1'b1;
      end else begin
        rnd_res = m_r[31:0];
      end
    end
    rnd_nx = gs & ~rnd_nv;
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    mag_d       = mag_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    sign_d      = sign_q;
    uns_d       = uns_q;
    rm_d        = rm_q;
    force_d     = force_q;
    force_res_d = force_res_q;
    result_d    = result_q;
    fflags_d    = fflags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d      = frs[31];
          uns_d       = is_unsigned;
          rm_d        = rm;
          force_d     = acc_force;
          force_res_d = acc_force_res;
          mag_d       = acc_mag;
          guard_d     = 1'b0;
          sticky_d    = acc_sticky;
          cnt_d       = acc_cnt;
          left_d      = acc_left;
          state_d     = acc_shift ? SHIFT : ROUND;
        end
      end
      SHIFT: begin
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
          if (left_q) begin
            mag_d = mag_q << 1;
          end else begin
            mag_d    = mag_q >> 1;
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
          end
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d    = rnd_res;
        fflags_d    = {rnd_nv, 3'b000, rnd_nx};
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      left_q      <= 1'b0;
      mag_q       <= 33'h0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      sign_q      <= 1'b0;
      uns_q       <= 1'b0;
      rm_q        <= 3'b000;
      force_q     <= 1'b0;
      force_res_q <= 32'h0;
      result_q    <= 32'h0;
      fflags_q    <= 5'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      mag_q       <= mag_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      sign_q      <= sign_d;
      uns_q       <= uns_d;
      rm_q        <= rm_d;
      force_q     <= force_d;
      force_res_q <= force_res_d;
      result_q    <= result_d;
      fflags_q    <= fflags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign fflags    = fflags_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fcvt_ws_seq.sv
// Directed and random checks of fcvt_ws_seq: results, flags, latency,
// handshake holding and mid-operation reset.
module tb_fcvt_ws_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] frs;
  logic [9:0]  class_res;
  logic [2:0]  rm;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;
  logic [1:0]  state_dbg;

  logic [36:0] exp_q[$];
  int          lat_q[$];
  int          total = 0;
  int          bad = 0;

  fcvt_ws_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .frs         (frs),
    .class_res   (class_res),
    .rm          (rm),
    .is_unsigned (is_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .fflags      (fflags),
    .state_dbg   (state_dbg)
  );

  // Clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] classify(input logic [31:0] f);
    logic [9:0] c;
    c = 10'b0;
    if (f[30:23] == 8'hFF) begin
      if (f[22:0] != 23'h0) c[f[22] ? 9 : 8] = 1'b1;
      else                  c[f[31] ? 0 : 7] = 1'b1;
    end else if (f[30:23] == 8'h00) begin
      if (f[22:0] == 23'h0) c[f[31] ? 3 : 4] = 1'b1;
      else                  c[f[31] ? 2 : 5] = 1'b1;
    end else begin
      c[f[31] ? 1 : 6] = 1'b1;
    end
    return c;
  endfunction

  function automatic int lat_of(input logic [31:0] f);
    int e;
    e = int'(f[30:23]) - 127;
    if (f[30:23] == 8'hFF || f[30:23] == 8'h00 || e < -1 || e >= 32) return 2;
    if (e <= 22) return 26 - e;
    return e - 20;
  endfunction

  // Real-arithmetic reference for normal operands
  task automatic model(input logic [31:0] f, input logic [2:0] r, input bit u,
                       output logic [31:0] res, output logic [4:0] fl);
    int     e;
    real    a, fl_r, fr, mag, rv;
    bit     neg, up, nv, inexact;
    longint li;
    e       = int'(f[30:23]) - 127;
    neg     = f[31];
    a       = real'({1'b1, f[22:0]}) * (2.0 ** (e - 23));
    fl_r    = $floor(a);
    fr      = a - fl_r;
    inexact = (fr != 0.0);
    case (r)
      3'd0:    up = (fr > 0.5) || (fr == 0.5 && (longint'(fl_r) % 2 == 1));
      3'd2:    up = neg && inexact;
      3'd3:    up = !neg && inexact;
      3'd4:    up = (fr >= 0.5);
      default: up = 1'b0;
    endcase
    mag = fl_r + (up ? 1.0 : 0.0);
    rv  = neg ? -mag : mag;
    nv  = 1'b0;
    res = 32'h0;
    if (!u) begin
      if (rv > 2147483647.0)       begin res = 32'h7FFF_FFFF; nv = 1'b1; end
      else if (rv < -2147483648.0) begin res = 32'h8000_0000; nv = 1'b1; end
      else begin li = longint'(rv); res = li[31:0]; end
    end else begin
      if (rv < 0.0)                begin res = 32'h0; nv = 1'b1; end
      else if (rv > 4294967295.0)  begin res = 32'hFFFF_FFFF; nv = 1'b1; end
      else begin li = longint'(rv); res = li[31:0]; end
    end
    fl = {nv, 3'b000, inexact & !nv};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Driver plus scoreboard pop; called #1 after a rising edge.
  task automatic run_op(input string tag, input logic [31:0] f, input logic [2:0] r,
                        input bit u, input logic [31:0] eres, input logic [4:0] efl,
                        input int hold);
    logic [36:0] e;
    int          lat;
    int          cyc;
    exp_q.push_back({eres, efl});
    lat_q.push_back(lat_of(f));
    frs         = f;
    class_res   = classify(f);
    rm          = r;
    is_unsigned = u;
    in_valid    = 1'b1;
    out_ready   = (hold == 0);
    #1;
    check({tag, "/in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    frs         = $urandom;
    class_res   = 10'($urandom);
    rm          = 3'($urandom);
    is_unsigned = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 45) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    e   = exp_q.pop_front();
    lat = lat_q.pop_front();
    check({tag, "/out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "/latency"}, cyc, lat);
    check({tag, "/result"}, result, e[36:5]);
    check({tag, "/fflags"}, {27'b0, fflags}, {27'b0, e[4:0]});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "/hold_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "/hold_result"}, result, e[36:5]);
      check({tag, "/hold_fflags"}, {27'b0, fflags}, {27'b0, e[4:0]});
      check({tag, "/hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, "/hold_state"}, {30'b0, state_dbg}, 32'd3);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "/post_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "/post_in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] f, mres;
    logic [4:0]  mfl;
    logic [2:0]  r;
    bit          u;

    rst         = 1'b1;
    in_valid    = 1'b0;
    frs         = 32'h0;
    class_res   = 10'h0;
    rm          = 3'd0;
    is_unsigned = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/in_ready", {31'b0, in_ready}, 32'd0);
    check("rst/out_valid", {31'b0, out_valid}, 32'd0);
    check("rst/state", {30'b0, state_dbg}, 32'd0);
    rst = 1'b0;
    #1;
    check("rel/in_ready", {31'b0, in_ready}, 32'd1);
    check("rel/result", result, 32'h0);
    check("rel/fflags", {27'b0, fflags}, 32'h0);
    @(posedge clk);
    #1;

    run_op("p1.5_rne",    32'h3FC0_0000, 3'd0, 1'b0, 32'h0000_0002, 5'h01, 0);
    run_op("m2.5_rne",    32'hC020_0000, 3'd0, 1'b0, 32'hFFFF_FFFE, 5'h01, 0);
    run_op("m2.5_rmm",    32'hC020_0000, 3'd4, 1'b0, 32'hFFFF_FFFD, 5'h01, 0);
    run_op("m2.5_rtz",    32'hC020_0000, 3'd1, 1'b0, 32'hFFFF_FFFE, 5'h01, 0);
    run_op("qnan_s",      32'h7FC0_0000, 3'd0, 1'b0, 32'h7FFF_FFFF, 5'h10, 0);
    run_op("snan_u",      32'h7F80_0001, 3'd0, 1'b1, 32'hFFFF_FFFF, 5'h10, 0);
    run_op("ninf_s",      32'hFF80_0000, 3'd0, 1'b0, 32'h8000_0000, 5'h10, 0);
    run_op("p2e31_s",     32'h4F00_0000, 3'd0, 1'b0, 32'h7FFF_FFFF, 5'h10, 0);
    run_op("p2e31_u",     32'h4F00_0000, 3'd0, 1'b1, 32'h8000_0000, 5'h00, 0);
    run_op("m2e31_s",     32'hCF00_0000, 3'd0, 1'b0, 32'h8000_0000, 5'h00, 0);
    run_op("m0.3_u_rtz",  32'hBE99_999A, 3'd1, 1'b1, 32'h0000_0000, 5'h01, 0);
    run_op("m0.3_s_rdn",  32'hBE99_999A, 3'd2, 1'b0, 32'hFFFF_FFFF, 5'h01, 0);
    run_op("m0.3_u_rdn",  32'hBE99_999A, 3'd2, 1'b1, 32'h0000_0000, 5'h10, 0);
    run_op("pzero",       32'h0000_0000, 3'd3, 1'b0, 32'h0000_0000, 5'h00, 0);
    run_op("p2e23",       32'h4B00_0000, 3'd0, 1'b0, 32'h0080_0000, 5'h00, 0);
    run_op("p0.5_rne",    32'h3F00_0000, 3'd0, 1'b0, 32'h0000_0000, 5'h01, 0);
    run_op("p0.5_rup",    32'h3F00_0000, 3'd3, 1'b1, 32'h0000_0001, 5'h01, 0);
    run_op("pinf_u",      32'h7F80_0000, 3'd0, 1'b1, 32'hFFFF_FFFF, 5'h10, 0);
    run_op("p1.5_hold",   32'h3FC0_0000, 3'd0, 1'b0, 32'h0000_0002, 5'h01, 5);

    // Reset in the middle of a long shift sequence
    frs       = 32'h3F00_0000;
    class_res = classify(32'h3F00_0000);
    rm        = 3'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid/state_shift", {30'b0, state_dbg}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid/in_ready_rst", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid/out_valid", {31'b0, out_valid}, 32'd0);
    check("mid/state_idle", {30'b0, state_dbg}, 32'd0);
    check("mid/in_ready", {31'b0, in_ready}, 32'd1);
    run_op("after_rst",   32'hC020_0000, 3'd0, 1'b0, 32'hFFFF_FFFE, 5'h01, 0);

    for (int k = 0; k < 24; k++) begin
      f = {1'($urandom), 8'($urandom_range(100, 165)), 23'($urandom)};
      r = 3'($urandom_range(0, 7));
      u = 1'($urandom_range(0, 1));
      model(f, r, u, mres, mfl);
      run_op("rnd", f, r, u, mres, mfl, k % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
